// File: rtl/debounce.sv
// Counter-based debouncer and edge detector for an already-synchronized input.
// A level change is accepted only after DEBOUNCE_CYCLES consecutive identical samples.
module debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_sig,
    output logic db_sig,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic glitch
);

    localparam logic [1:0] S_LOW      = 2'd0;
    localparam logic [1:0] S_CHK_HIGH = 2'd1;
    localparam logic [1:0] S_HIGH     = 2'd2;
    localparam logic [1:0] S_CHK_LOW  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             glitch_q, glitch_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        db_d     = db_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        glitch_d = 1'b0;
        case (state_q)
            S_LOW: begin
                if (sync_sig) begin
                    state_d = S_CHK_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            S_CHK_HIGH: begin
                if (!sync_sig) begin
                    state_d  = S_LOW;
                    cnt_d    = '0;
                    glitch_d = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                    db_d    = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!sync_sig) begin
                    state_d = S_CHK_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            S_CHK_LOW: begin
                // Aborted low-going check falls back to the held high level.
                if (sync_sig) begin
                    state_d  = S_HIGH;
                    cnt_d    = '0;
                    glitch_d = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                    db_d    = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
                db_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_LOW;
            cnt_q    <= '0;
            db_q     <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            db_q     <= db_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    assign db_sig     = db_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign glitch     = glitch_q;

endmodule

// File: tb/tb_debounce.sv
// Bench for debounce: two instances (DEBOUNCE_CYCLES=4 and 2) checked every cycle
// against a run-length reference model, plus directed checks from the test plan.
module tb_debounce;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sync4 = 1'b0;
    logic sync2 = 1'b0;
    logic db4, rise4, fall4, gl4;
    logic db2, rise2, fall2, gl2;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state, index 0 -> D=4 instance, index 1 -> D=2 instance
    int   md[2] = '{4, 2};
    logic mL[2];
    int   mn[2];
    logic mr[2];
    logic mf[2];
    logic mg[2];

    always #20 clk = ~clk;

    debounce #(.DEBOUNCE_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .sync_sig(sync4),
        .db_sig(db4), .rise_pulse(rise4), .fall_pulse(fall4), .glitch(gl4)
    );

    debounce #(.DEBOUNCE_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .sync_sig(sync2),
        .db_sig(db2), .rise_pulse(rise2), .fall_pulse(fall2), .glitch(gl2)
    );

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0b, expected %0b", tag, obs, exp);
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mL[i] = 1'b0; mn[i] = 0; mr[i] = 1'b0; mf[i] = 1'b0; mg[i] = 1'b0;
        end
    endtask

    // Count consecutive samples differing from the accepted level; accept at D.
    task automatic model_step(input int i, input logic s);
        mr[i] = 1'b0; mf[i] = 1'b0; mg[i] = 1'b0;
        if (s != mL[i]) begin
            mn[i]++;
            if (mn[i] == md[i]) begin
                mL[i] = s;
                mn[i] = 0;
                if (s) mr[i] = 1'b1;
                else   mf[i] = 1'b1;
            end
        end else begin
            if (mn[i] > 0) mg[i] = 1'b1;
            mn[i] = 0;
        end
    endtask

    task automatic check_all();
        check_bit("db4",    db4,   mL[0]);
        check_bit("rise4",  rise4, mr[0]);
        check_bit("fall4",  fall4, mf[0]);
        check_bit("glitch4", gl4,  mg[0]);
        check_bit("db2",    db2,   mL[1]);
        check_bit("rise2",  rise2, mr[1]);
        check_bit("fall2",  fall2, mf[1]);
        check_bit("glitch2", gl2,  mg[1]);
    endtask

    // Drive both inputs, take one rising edge, then compare just after it.
    task automatic cyc(input logic a, input logic b);
        sync4 = a;
        sync2 = b;
        @(posedge clk);
        if (rst) model_reset();
        else begin
            model_step(0, a);
            model_step(1, b);
        end
        #1;
        check_all();
    endtask

    task automatic async_reset_pulse();
        #10 rst = 1'b1;
        model_reset();
        #1 check_all();
        #10 rst = 1'b0;
    endtask

    initial begin
        int gcnt4;
        int gcnt2;
        logic v;
        int hold;
        model_reset();

        // Reset held with input high for three cycles
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
        rst = 1'b0;

        // Release while input is high: qualified as a fresh rise
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        check_bit("rise2_after_release", rise2, 1'b1);
        cyc(1'b1, 1'b1);
        check_bit("db4_not_yet", db4, 1'b0);
        cyc(1'b1, 1'b1);
        check_bit("rise4_after_release", rise4, 1'b1);
        check_bit("db4_high", db4, 1'b1);
        cyc(1'b1, 1'b1);

        // Glitch low then clean fall
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1);
        check_bit("glitch_low4", gl4, 1'b1);
        check_bit("db4_held_high", db4, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        check_bit("fall4_clean", fall4, 1'b1);
        check_bit("db4_low", db4, 1'b0);

        // Glitch high then clean rise
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b0);
        check_bit("glitch_high4", gl4, 1'b1);
        check_bit("no_rise4", rise4, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        check_bit("rise4_clean", rise4, 1'b1);

        // Back to low, then reset asynchronously mid-check
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        check_bit("db2_high_before_rst", db2, 1'b1);
        async_reset_pulse();
        check_bit("async_rst_db2", db2, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
        check_bit("db4_wait_after_rst", db4, 1'b0);
        cyc(1'b1, 1'b1);
        check_bit("db4_after_rst", db4, 1'b1);
        check_bit("rise4_after_rst", rise4, 1'b1);

        // Toggle every cycle from LOW for 20 cycles
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);
        gcnt4 = 0;
        gcnt2 = 0;
        for (int i = 0; i < 20; i++) begin
            v = (i % 2 == 0);
            cyc(v, v);
            if (gl4 === 1'b1) gcnt4++;
            if (gl2 === 1'b1) gcnt2++;
        end
        check_int("toggle_glitches2", gcnt2, 10);
        check_int("toggle_glitches4", gcnt4, 10);
        check_bit("toggle_db2", db2, 1'b0);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        check_bit("rise2_min_param", rise2, 1'b1);

        // Randomized runs with varying hold lengths and occasional async reset
        for (int i = 0; i < 120; i++) begin
            v = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 6);
            for (int j = 0; j < hold; j++) cyc(v, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 29) == 0) async_reset_pulse();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/debounce.md
# debounce

Counter-based debouncer and edge detector that sits directly downstream of the `sync` synchronizer. It consumes the already-synchronized `sync_sig` and qualifies each level change: the input must hold stable for `DEBOUNCE_CYCLES` consecutive clock samples before the change is accepted. It produces a clean level plus single-cycle rise, fall and glitch pulses for downstream control logic.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive identical samples required to accept a level change. Legal range is 2..2^20.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: width of the stability counter. Derived; not overridden.
- `clk` input 1: single clock; all logic samples on the rising edge.
- `rst` input 1: asynchronous reset, active-high.
- `sync_sig` input 1: synchronized input from the `sync` stage. It is not re-synchronized here.
- `db_sig` output 1: debounced level.
- `rise_pulse` output 1: one-cycle pulse when `db_sig` goes 0->1.
- `fall_pulse` output 1: one-cycle pulse when `db_sig` goes 1->0.
- `glitch` output 1: one-cycle pulse when a pending change is aborted.

## Operation
- The FSM has four states: LOW, CHK_HIGH, HIGH, CHK_LOW.
- **Reset state:** LOW, cnt=0, `db_sig`=0, `rise_pulse`=0, `fall_pulse`=0, `glitch`=0.
- **LOW:**
  - `sync_sig`=1 -> CHK_HIGH with cnt=1.
  - Otherwise stay in LOW with cnt=0.
- **CHK_HIGH:**
  - `sync_sig`=0 -> LOW, cnt=0, `glitch`=1 for one cycle.
  - `sync_sig`=1 and cnt==DEBOUNCE_CYCLES-1 -> HIGH, cnt=0, `db_sig`=1, `rise_pulse`=1 for one cycle.
  - Otherwise cnt increments.
- **HIGH / CHK_LOW:** exact mirror of the above with polarity inverted. Exit to LOW asserts `fall_pulse`. An aborted check returns to HIGH and asserts `glitch`.
- `db_sig` changes only on the HIGH/LOW transitions. It is constant during CHK_* states and holds the old level.
- At most one of `rise_pulse`, `fall_pulse`, `glitch` is high in any cycle.
- cnt never exceeds DEBOUNCE_CYCLES-1. No wrap-around is possible, and cnt is cleared on every state exit.
- The input may toggle every cycle indefinitely:
  - The FSM alternates LOW<->CHK_HIGH.
  - `glitch` pulses on every abort.
  - `db_sig` never changes.
- All outputs are registered. There are no combinational paths from `sync_sig` to any output.

## Timing
- Let edge k be the first rising edge that samples the new level.
- If the level holds through edge k+DEBOUNCE_CYCLES-1:
  - `db_sig` and the matching edge pulse update immediately after that edge.
  - Latency is DEBOUNCE_CYCLES edges from first sample.
  - Total from `async_sig` change: NUM_FFS + DEBOUNCE_CYCLES edges.
- Edge pulses and `glitch` are high for exactly one clock period, coincident with the state transition.
- **Reset asserted mid-check:** all outputs go to 0 and the state to LOW immediately, without waiting for `clk`. Any in-progress count is discarded.
- **After reset release:** a level of 1 needs the full DEBOUNCE_CYCLES samples, counted from the first rising edge after release.
- **Reset release while `sync_sig`=1:** treated as a new change and qualified normally. It produces a `rise_pulse`.

## Test plan
Clock period is 40 ns; DEBOUNCE_CYCLES=4 unless stated.

- **Reset:** assert `rst` with `sync_sig`=1 for 3 cycles -> `db_sig`, `rise_pulse`, `fall_pulse`, `glitch` all 0 throughout. The state returns to LOW asynchronously, checked mid-cycle.
- **Clean rise:** drive `sync_sig`=1 before edge k and hold -> `db_sig`=1 after edge k+3, `rise_pulse`=1 for exactly the cycle after edge k+3, `glitch` never asserts.
- **Glitch high:** `sync_sig`=1 for samples k..k+2, 0 at k+3 -> `db_sig` stays 0, `glitch`=1 for one cycle after edge k+3, no `rise_pulse`. A following clean 4-cycle high then yields `rise_pulse`.
- **Clean fall and glitch low:** from HIGH, `sync_sig`=0 for 2 samples then 1 -> one `glitch` and `db_sig` stays 1. Then 0 held for 4 samples -> `db_sig`=0 and `fall_pulse`=1 for one cycle.
- **Reset mid-check:** assert `rst` asynchronously after 2 samples of 1, release, keep `sync_sig`=1 -> `db_sig`=1 only after the 4th edge following release.
- **Minimum parameter and toggling:** with DEBOUNCE_CYCLES=2, toggle `sync_sig` every cycle for 20 cycles -> `db_sig`=0 throughout and `glitch` pulses 10 times. Then hold 1 for 2 samples -> `rise_pulse`.
